// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory responder: FSM encoding, address
// map, RAM geometry and the latched request record.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [12:0] ROM_LAST  = 13'h17FF;
  localparam logic [12:0] RAM_BASE  = 13'h1800;
  localparam int          RAM_DEPTH = 2048;
  localparam int          RAM_AW    = $clog2(RAM_DEPTH);

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
    logic        rd;
    logic        wr;
    logic        rom_sel;
    logic        ram_sel;
  } req_t;

  // Illegal combinations still complete normally, but flag err and touch nothing.
  function automatic logic req_is_error(input req_t r);
    return (r.wr && r.rom_sel) || (r.rd && r.wr) ||
           (r.rom_sel && r.ram_sel) || !(r.rom_sel || r.ram_sel);
  endfunction

  function automatic logic [3:0] req_wait(input req_t r,
                                          input logic [3:0] rom_w,
                                          input logic [3:0] ram_w);
    if (r.rom_sel) return rom_w;
    if (r.ram_sel) return ram_w;
    return 4'd0;
  endfunction

  function automatic logic addr_in_rom(input logic [12:0] a);
    return a <= ROM_LAST;
  endfunction

  function automatic logic addr_in_ram(input logic [12:0] a);
    return a >= RAM_BASE;
  endfunction

endpackage

// File: rtl/mem_responder_ram.sv
// 2048 x 8 RAM with synchronous write and combinational read.
module ram_2kx8
  import mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Bus responder for a ROM/RAM pair: latches a request, waits the region's
// wait count, then completes with a one-cycle rdy (and err for bad requests).
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ROM_WAIT = 2,
  parameter int RAM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [7:0]  data_in,
  input  logic        rom_sel,
  input  logic        ram_sel,
  output logic [7:0]  data_out,
  output logic        rdy,
  output logic        err,
  output logic [12:0] rom_addr,
  input  logic [7:0]  rom_data
);

  localparam logic [3:0] ROM_W = 4'(ROM_WAIT);
  localparam logic [3:0] RAM_W = 4'(RAM_WAIT);

  state_t      state, next_state;
  req_t        live_req, lat_req, cur_req;
  logic [3:0]  wait_cnt, cur_wait;
  logic        accept, cur_err, enter_done;
  logic        ram_we, load_data, rdy_d, err_d;
  logic [7:0]  ram_rdata, load_value;

  always_comb begin
    live_req = '{addr: addr, data: data_in, rd: rd, wr: wr,
                 rom_sel: rom_sel, ram_sel: ram_sel};
  end

  // In IDLE the live bus is the request; afterwards only the latched copy counts.
  always_comb begin
    cur_req  = (state == IDLE) ? live_req : lat_req;
    cur_err  = req_is_error(cur_req);
    cur_wait = req_wait(cur_req, ROM_W, RAM_W);
    accept   = (state == IDLE) && (rd || wr) && !rdy;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (cur_wait != 4'd0) ? WAIT : DONE;
      WAIT:    if (wait_cnt <= 4'd1) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // rdy/err are registered from DONE, so the pulse lands one edge after DONE begins.
  always_comb begin
    enter_done = (next_state == DONE) && (state != DONE);
    ram_we     = enter_done && !rst && cur_req.wr && !cur_err;
    load_data  = enter_done && cur_req.rd && !cur_err;
    load_value = cur_req.rom_sel ? rom_data : ram_rdata;
    rdy_d      = (state == DONE);
    err_d      = (state == DONE) && cur_err;
    rom_addr   = rst ? 13'h0000 : cur_req.addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_req  <= '0;
      wait_cnt <= 4'd0;
    end else begin
      if (accept) lat_req <= live_req;
      case (state)
        IDLE:    wait_cnt <= accept ? cur_wait : 4'd0;
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        default: wait_cnt <= 4'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy      <= 1'b0;
      err      <= 1'b0;
      data_out <= 8'h00;
    end else begin
      rdy <= rdy_d;
      err <= err_d;
      if (load_data) data_out <= load_value;
    end
  end

  ram_2kx8 u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cur_req.addr[RAM_AW-1:0]),
    .wdata (cur_req.data),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (RAM_WAIT 0 and 3) driven
// with directed and random requests against a high-level memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NUM    = 2;
  localparam int ROM_W  = 2;
  localparam int RAM_W0 = 0;
  localparam int RAM_W1 = 3;

  typedef struct {
    int         cyc;
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_s      [NUM];
  logic [12:0] addr_s     [NUM];
  logic        rd_s       [NUM];
  logic        wr_s       [NUM];
  logic [7:0]  data_in_s  [NUM];
  logic        rom_sel_s  [NUM];
  logic        ram_sel_s  [NUM];
  logic [7:0]  data_out_s [NUM];
  logic        rdy_s      [NUM];
  logic        err_s      [NUM];
  logic [12:0] rom_addr_s [NUM];
  logic [7:0]  rom_data_s [NUM];

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q0 [$];
  exp_t exp_q1 [$];
  logic [7:0] ram_m   [NUM][RAM_DEPTH];
  logic [7:0] last_rd [NUM];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < NUM; g++) begin : g_dut
      mem_responder #(
        .ROM_WAIT (ROM_W),
        .RAM_WAIT ((g == 0) ? RAM_W0 : RAM_W1)
      ) dut (
        .clk      (clk),
        .rst      (rst_s[g]),
        .addr     (addr_s[g]),
        .rd       (rd_s[g]),
        .wr       (wr_s[g]),
        .data_in  (data_in_s[g]),
        .rom_sel  (rom_sel_s[g]),
        .ram_sel  (ram_sel_s[g]),
        .data_out (data_out_s[g]),
        .rdy      (rdy_s[g]),
        .err      (err_s[g]),
        .rom_addr (rom_addr_s[g]),
        .rom_data (rom_data_s[g])
      );
      assign rom_data_s[g] = rom_addr_s[g][7:0];
    end
  endgenerate

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int g, input exp_t ex);
    if (g == 0) exp_q0.push_back(ex);
    else        exp_q1.push_back(ex);
  endtask

  task automatic pop_exp(input int g, output exp_t ex, output bit ok);
    ok = 1'b0;
    ex = '{cyc: 0, err: 1'b0, data: 8'h00};
    if (g == 0 && exp_q0.size() > 0) begin ex = exp_q0.pop_front(); ok = 1'b1; end
    if (g == 1 && exp_q1.size() > 0) begin ex = exp_q1.pop_front(); ok = 1'b1; end
  endtask

  function automatic int wait_of(input int g, input logic rs, input logic ms);
    if (rs) return ROM_W;
    if (ms) return (g == 0) ? RAM_W0 : RAM_W1;
    return 0;
  endfunction

  function automatic logic [12:0] win_addr(input int idx);
    return (idx < 16) ? 13'(32'h1800 + idx) : 13'(32'h1FF0 + idx - 16);
  endfunction

  // Monitor: every rdy pulse must match the oldest outstanding expectation.
  task automatic check_output(input int g);
    exp_t ex;
    bit   ok;
    pop_exp(g, ex, ok);
    if (!ok) begin
      tests++;
      fails++;
      $display("[TB] FAIL g%0d unexpected rdy: got rdy=1 at cycle %0d, required no completion", g, cyc);
    end else begin
      compare($sformatf("g%0d rdy cycle", g), cyc, ex.cyc);
      compare($sformatf("g%0d err", g), err_s[g], ex.err);
      compare($sformatf("g%0d data_out", g), data_out_s[g], ex.data);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NUM; g++)
      if (rdy_s[g] === 1'b1) check_output(g);
  end

  // Drive one request (held for 'pulses' completions) and update the model.
  task automatic apply_stimulus(input int g, input logic r, input logic w,
                                input logic [12:0] a, input logic [7:0] d,
                                input logic rs, input logic ms, input int pulses);
    int   n, n0, wt, seen, budget;
    logic e;
    bit   rom_rd;
    exp_t ex;
    @(negedge clk);
    rd_s[g] = r;  wr_s[g] = w;  addr_s[g] = a;  data_in_s[g] = d;
    rom_sel_s[g] = rs;  ram_sel_s[g] = ms;
    #1 compare($sformatf("g%0d idle rom_addr", g), rom_addr_s[g], a);
    n      = cyc + 1;
    n0     = n;
    wt     = wait_of(g, rs, ms);
    e      = (w && rs) || (r && w) || (rs && ms) || (!rs && !ms);
    rom_rd = r && !e && rs;
    for (int p = 0; p < pulses; p++) begin
      if (!e) begin
        if (w) ram_m[g][a[10:0]] = d;
        if (r) last_rd[g] = rs ? a[7:0] : ram_m[g][a[10:0]];
      end
      ex.cyc  = n + 1 + wt;
      ex.err  = e;
      ex.data = last_rd[g];
      push_exp(g, ex);
      n = ex.cyc + 2;
    end
    seen   = 0;
    budget = 0;
    while (seen < pulses && budget < 40) begin
      @(negedge clk);
      budget++;
      if (rom_rd && cyc <= n0 + wt)
        compare($sformatf("g%0d rom_addr hold", g), rom_addr_s[g], a);
      if (pulses == 1 && cyc == n0) begin
        addr_s[g]    = 13'($urandom);
        data_in_s[g] = 8'($urandom);
        rom_sel_s[g] = 1'($urandom);
        ram_sel_s[g] = 1'($urandom);
      end
      if (rdy_s[g] === 1'b1) begin
        seen++;
        if (seen == pulses) begin rd_s[g] = 1'b0; wr_s[g] = 1'b0; end
      end
    end
    if (seen < pulses) begin
      tests++;
      fails++;
      $display("[TB] FAIL g%0d timeout: got %0d rdy pulses, required %0d", g, seen, pulses);
      rd_s[g] = 1'b0;
      wr_s[g] = 1'b0;
      if (g == 0) exp_q0.delete();
      else        exp_q1.delete();
    end
  endtask

  task automatic issue(input int g, input logic r, input logic w,
                       input logic [12:0] a, input logic [7:0] d);
    apply_stimulus(g, r, w, a, d, addr_in_rom(a), addr_in_ram(a), 1);
  endtask

  task automatic check_reset(input int g);
    compare($sformatf("g%0d reset rdy", g), rdy_s[g], 1'b0);
    compare($sformatf("g%0d reset err", g), err_s[g], 1'b0);
    compare($sformatf("g%0d reset data_out", g), data_out_s[g], 8'h00);
    compare($sformatf("g%0d reset rom_addr", g), rom_addr_s[g], 13'h0000);
  endtask

  task automatic reset_abort(input int g);
    int n;
    @(negedge clk);
    wr_s[g] = 1'b1;  rd_s[g] = 1'b0;  addr_s[g] = 13'h1801;  data_in_s[g] = 8'h11;
    rom_sel_s[g] = 1'b0;  ram_sel_s[g] = 1'b1;
    n = cyc + 1;
    while (cyc < n + 1) @(negedge clk);
    rst_s[g] = 1'b1;
    wr_s[g]  = 1'b0;
    #1 check_reset(g);
    last_rd[g] = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 rst_s[g] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      compare($sformatf("g%0d aborted rdy", g), rdy_s[g], 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < NUM; g++) begin
      rst_s[g] = 1'b1;  addr_s[g] = 13'h0ABC;  rd_s[g] = 1'b0;  wr_s[g] = 1'b0;
      data_in_s[g] = 8'h00;  rom_sel_s[g] = 1'b0;  ram_sel_s[g] = 1'b0;
      last_rd[g] = 8'h00;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < NUM; g++) check_reset(g);
    @(posedge clk);
    #1 for (int g = 0; g < NUM; g++) rst_s[g] = 1'b0;

    for (int g = 0; g < NUM; g++)
      for (int i = 0; i < 32; i++) issue(g, 1'b0, 1'b1, win_addr(i), 8'($urandom));

    $display("[TB] directed accesses");
    issue(0, 1'b0, 1'b1, 13'h1800, 8'hA5);
    issue(0, 1'b1, 1'b0, 13'h1800, 8'h00);
    issue(0, 1'b1, 1'b0, 13'h0123, 8'h00);
    issue(0, 1'b0, 1'b1, 13'h0800, 8'h5A);
    issue(0, 1'b1, 1'b0, 13'h0800, 8'h00);
    issue(0, 1'b1, 1'b0, 13'h08A7, 8'h00);
    issue(0, 1'b0, 1'b1, 13'h1FFF, 8'h3C);
    issue(0, 1'b1, 1'b1, 13'h1FFF, 8'hC3);
    issue(0, 1'b1, 1'b0, 13'h1FFF, 8'h00);
    apply_stimulus(0, 1'b1, 1'b0, 13'h1802, 8'h00, 1'b0, 1'b1, 2);
    apply_stimulus(0, 1'b1, 1'b0, 13'h1003, 8'h00, 1'b1, 1'b1, 1);
    apply_stimulus(0, 1'b1, 1'b0, 13'h1804, 8'h00, 1'b0, 1'b0, 1);

    $display("[TB] random accesses");
    for (int g = 0; g < NUM; g++) begin
      for (int i = 0; i < 60; i++) begin
        logic [12:0] a;
        a = win_addr($urandom_range(0, 31));
        case ($urandom_range(0, 7))
          0, 1: issue(g, 1'b0, 1'b1, a, 8'($urandom));
          2, 3: issue(g, 1'b1, 1'b0, a, 8'h00);
          4:    issue(g, 1'b1, 1'b0, 13'($urandom_range(0, 32'h17FF)), 8'h00);
          5:    issue(g, 1'b0, 1'b1, 13'($urandom_range(0, 32'h17FF)), 8'($urandom));
          6:    issue(g, 1'b1, 1'b1, a, 8'($urandom));
          default: begin
            logic both, r;
            both = 1'($urandom);
            r    = 1'($urandom);
            apply_stimulus(g, r, !r, 13'($urandom), 8'($urandom), both, both, 1);
          end
        endcase
      end
    end

    $display("[TB] reset during wait");
    issue(1, 1'b0, 1'b1, 13'h1801, 8'h77);
    reset_abort(1);
    issue(1, 1'b1, 1'b0, 13'h1801, 8'h00);
    issue(1, 1'b1, 1'b0, 13'h0456, 8'h00);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ROM_WAIT, default 2, extra wait cycles for a ROM read (0..15).
REQ-002 SHALL have parameter RAM_WAIT, default 0, extra wait cycles for a RAM access (0..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 addr  input  13  bus address from the initiator.
REQ-006 rd  input  1  read request, held by the initiator until rdy.
REQ-007 wr  input  1  write request, held by the initiator until rdy.
REQ-008 data_in  input  8  write data.
REQ-009 rom_sel  input  1  ROM select from the address decoder (addr 0x0000-0x17FF).
REQ-010 ram_sel  input  1  RAM select from the address decoder (addr 0x1800-0x1FFF).
REQ-011 data_out  output  8  read data, valid while rdy=1.
REQ-012 rdy  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle error flag, coincident with rdy.
REQ-014 rom_addr  output  13  address to the external ROM.
REQ-015 rom_data  input  8  external ROM data, combinational from rom_addr.

Function
REQ-016 SHALL contain a 2048 x 8 RAM, indexed by addr[10:0].
REQ-017 SHALL implement a three-state FSM:
- IDLE: waiting for a request.
- WAIT: counting down the wait cycles.
- DONE: completing the access.
REQ-018 In IDLE, a request SHALL be accepted when rd or wr is high at a rising edge; addr, data_in, rd, wr, rom_sel and ram_sel SHALL be latched at that edge.
REQ-019 After acceptance, the FSM SHALL go to WAIT if the selected wait count is nonzero, otherwise to DONE.
REQ-020 WAIT SHALL last exactly the selected wait count in cycles (ROM_WAIT for ROM, RAM_WAIT for RAM), then go to DONE.
REQ-021 Latency: acceptance at edge N puts rdy high for the single cycle following edge N+1+wait.
REQ-022 DONE SHALL assert rdy for exactly one cycle and always go to IDLE.
REQ-023 Changes on the request inputs after acceptance SHALL be ignored until the FSM returns to IDLE.
REQ-024 A request still high in the cycle after rdy SHALL be accepted again as a new request; the initiator drops rd/wr during the rdy cycle.
REQ-025 RAM write: the latched data SHALL be committed at the edge entering DONE.
REQ-026 RAM read: data_out SHALL equal RAM[latched addr[10:0]] during DONE.
REQ-027 ROM read: rom_addr SHALL present the latched address from WAIT through DONE.
REQ-028 ROM read: data_out SHALL register rom_data at the edge entering DONE.
REQ-029 data_out SHALL hold its last read value until the next read completes; writes SHALL NOT change it.
REQ-030 Error cases SHALL complete with the normal timing for the decoded region (0 waits if unselected), with rdy=1, err=1, and no RAM change:
- write with rom_sel=1;
- rd and wr both high;
- rom_sel and ram_sel both high;
- neither select high.
REQ-031 In IDLE, rom_addr SHALL follow addr.

Reset
REQ-032 While rst is high: FSM in IDLE, wait counter 0, rdy=0, err=0, data_out=8'h00, rom_addr=13'h0000.
REQ-033 rst asserted mid-access SHALL abort the access; a write that has not reached DONE SHALL NOT commit.
REQ-034 RAM contents SHALL NOT be cleared by reset.
REQ-035 The first request SHALL be accepted at the first rising edge after rst deasserts.

Structure
REQ-036 A shared package SHALL hold:
- the FSM state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
- the address-map constants (ROM_LAST=13'h17FF, RAM_BASE=13'h1800);
- the RAM depth (2048).
REQ-037 The RAM array SHALL be a sub-module ram_2kx8: clk, we, addr[10:0], wdata[7:0], synchronous write, combinational read.
REQ-038 Select decoding SHALL stay external; this block consumes rom_sel and ram_sel only.

Verification
REQ-039 Default parameters, write 8'hA5 to 0x1800, then read 0x1800 -> each access shows rdy one cycle after acceptance, err=0, read data_out=8'hA5.
REQ-040 ROM_WAIT=2, ROM model returns addr[7:0], read 0x0123 -> rdy exactly 3 cycles after acceptance, data_out=8'h23, rom_addr=0x0123 through DONE.
REQ-041 Write 8'h5A to 0x0800 (rom_sel=1) -> rdy=1 with err=1, and a later read of 0x0800 still returns ROM data.
REQ-042 rd=wr=1 at 0x1FFF -> err=1 with rdy, RAM[0x7FF] unchanged.
REQ-043 RAM_WAIT=3, write 8'h11 to 0x1801, rst pulsed during WAIT -> rdy never asserted, and a later read of 0x1801 returns the prior value.
REQ-044 rd held high across rdy at 0x1802 -> two back-to-back completions, each with rdy high for exactly one cycle and one IDLE cycle between them.
